// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter that shares one external saturating adder among NUM_REQ
// requesters; one operation in flight, with a watchdog abort on a silent adder.
module sat_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BIT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_y,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [BIT_WIDTH-1:0]           rsp_data,
  output logic                           rsp_err,
  output logic [BIT_WIDTH-1:0]           add_x,
  output logic [BIT_WIDTH-1:0]           add_y,
  output logic                           add_start,
  input  logic                           add_done,
  input  logic [BIT_WIDTH-1:0]           add_result,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      gnt_q, gnt_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [BIT_WIDTH-1:0]  add_x_q, add_x_d;
  logic [BIT_WIDTH-1:0]  add_y_q, add_y_d;
  logic [BIT_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  done_q;

  logic                  gnt_found;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  completion;

  // Search upward from rr_ptr, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      cand = sum[IDX_W-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A done level carried over from the previous op must not complete this one.
  assign completion = add_done & ~done_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    timer_d    = timer_q;
    add_x_d    = add_x_q;
    add_y_d    = add_y_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    rsp_valid  = '0;
    add_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          add_x_d = req_x[gnt_idx*BIT_WIDTH +: BIT_WIDTH];
          add_y_d = req_y[gnt_idx*BIT_WIDTH +: BIT_WIDTH];
          gnt_d   = gnt_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        add_start = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (completion) begin
          rsp_data_d = add_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == TMR_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rr_ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + IDX_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      timer_q    <= '0;
      add_x_q    <= '0;
      add_y_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      timer_q    <= timer_d;
      add_x_q    <= add_x_d;
      add_y_q    <= add_y_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      done_q     <= add_done;
    end
  end

  assign add_x    = add_x_q;
  assign add_y    = add_y_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = (state_q != S_IDLE);

endmodule
